letter_ps2_tx: RTL

//  Inverse of the keyboard letter decoder: takes a letter index (0-25 = A-Z, 26 = Enter),

---
 rtl/letter_ps2_tx_pkg.sv | 53 +++++
 rtl/letter_ps2_tx_encoder.sv | 47 ++++
 rtl/letter_ps2_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/letter_ps2_tx_pkg.sv
// Shared definitions for the letter-to-PS/2 transmitter: the set-2 scancodes,
// the letter index constants, the frame width and the FSM state type.
package letter_ps2_tx_pkg;

    localparam int FRAME_W = 11;

    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam logic [4:0] LETTER_ENTER = 5'd26;
    localparam logic [4:0] LETTER_NONE  = 5'd27;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A;
    localparam logic [7:0] SC_N = 8'h31;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_Z = 8'h1A;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIT_HI = 2'd1,
        ST_BIT_LO = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Builds the wire-order frame (bit 0 goes out first): start, data LSB first,
    // odd parity, stop.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] data);
        return {1'b1, ~(^data), data, 1'b0};
    endfunction

endpackage

// File: rtl/letter_ps2_tx_encoder.sv
// Letter index to PS/2 set-2 make code; exact inverse of the keyboard letter
// decoder. Indices 27-31 have no key and report valid=0.
module letter_encoder
    import letter_ps2_tx_pkg::*;
(
    input  logic [4:0] letter,
    output logic       valid,
    output logic [7:0] code
);

    // Pure lookup; unmapped indices fall through to the default.
    always_comb begin
        valid = 1'b1;
        code  = 8'h00;
        case (letter)
            5'd0:  code = SC_A;
            5'd1:  code = SC_B;
            5'd2:  code = SC_C;
            5'd3:  code = SC_D;
            5'd4:  code = SC_E;
            5'd5:  code = SC_F;
            5'd6:  code = SC_G;
            5'd7:  code = SC_H;
            5'd8:  code = SC_I;
            5'd9:  code = SC_J;
            5'd10: code = SC_K;
            5'd11: code = SC_L;
            5'd12: code = SC_M;
            5'd13: code = SC_N;
            5'd14: code = SC_O;
            5'd15: code = SC_P;
            5'd16: code = SC_Q;
            5'd17: code = SC_R;
            5'd18: code = SC_S;
            5'd19: code = SC_T;
            5'd20: code = SC_U;
            5'd21: code = SC_V;
            5'd22: code = SC_W;
            5'd23: code = SC_X;
            5'd24: code = SC_Y;
            5'd25: code = SC_Z;
            LETTER_ENTER: code = SC_ENTER;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/letter_ps2_tx.sv
// Device-side PS/2 transmitter: serialises the scancode of a letter index as
// make (and optionally F0 + code break) frames, standing in for a keyboard.
//
// Request handshake: a request is taken on a rising clock edge where in_valid
// and in_ready are both high; in_letter is sampled only on that edge. in_ready
// is high only while idle and the host is not holding the clock line low, and
// in_valid may be held high across transactions.
module letter_ps2_tx
    import letter_ps2_tx_pkg::*;
#(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000,
    parameter bit SEND_BREAK = 1'b1
)(
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] in_letter,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_o,
    output logic       ps2_dat_o,
    output logic       done,
    output logic       err,
    output logic [1:0] state_dbg
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0] LAST_BYTE = SEND_BREAK ? 2'd2 : 2'd0;
    localparam logic [3:0] STOP_POS  = 4'(FRAME_W - 1);

    state_t               state, state_next;
    logic                 sync_ff1, clk_s, inhibit, accept;
    logic [CNT_W-1:0]     div_cnt;
    logic [3:0]           bit_cnt;
    logic [1:0]           byte_cnt;
    logic [7:0]           code_q;
    logic [FRAME_W-1:0]   frame_q;
    logic                 enc_valid;
    logic [7:0]           enc_code;
    logic                 clr_div, load, shift, next_frame, set_done, set_err;

    letter_encoder u_encoder (
        .letter (in_letter),
        .valid  (enc_valid),
        .code   (enc_code)
    );

    // Two-flop synchroniser on the sensed clock line; resets to "released".
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_ff1 <= 1'b1;
            clk_s    <= 1'b1;
        end else begin
            sync_ff1 <= ps2_clk_in;
            clk_s    <= sync_ff1;
        end
    end

    assign inhibit   = ~clk_s;
    assign in_ready  = (state == ST_IDLE) && clk_s;
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    // Lines are decoded from state so an async reset releases them immediately.
    assign ps2_clk_o = (state != ST_BIT_LO);
    assign ps2_dat_o = (state == ST_BIT_HI || state == ST_BIT_LO) ? frame_q[0] : 1'b1;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        clr_div    = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        next_frame = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                clr_div = 1'b1;
                if (accept) begin
                    if (enc_valid) begin
                        state_next = ST_BIT_HI;
                        load       = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            ST_BIT_HI: begin
                // Once the stop bit is on the wire the frame is committed.
                if (inhibit && bit_cnt != STOP_POS) begin
                    state_next = ST_IDLE;
                    set_err    = 1'b1;
                end else if (div_cnt == DIV_LAST) begin
                    state_next = ST_BIT_LO;
                    clr_div    = 1'b1;
                end
            end
            ST_BIT_LO: begin
                // We are pulling the clock low ourselves, so inhibit is not visible here.
                if (div_cnt == DIV_LAST) begin
                    clr_div = 1'b1;
                    if (bit_cnt != STOP_POS) begin
                        state_next = ST_BIT_HI;
                        shift      = 1'b1;
                    end else if (byte_cnt == LAST_BYTE) begin
                        state_next = ST_IDLE;
                        set_done   = 1'b1;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (inhibit) begin
                    state_next = ST_IDLE;
                    set_err    = 1'b1;
                end else if (div_cnt == GAP_LAST) begin
                    state_next = ST_BIT_HI;
                    next_frame = 1'b1;
                    clr_div    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Divider, bit/byte counters, frame shifter and status pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            code_q   <= '0;
            frame_q  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            div_cnt <= clr_div ? '0 : div_cnt + 1'b1;
            if (load) begin
                code_q   <= enc_code;
                frame_q  <= make_frame(enc_code);
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (shift) begin
                frame_q <= {1'b1, frame_q[FRAME_W-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end else if (next_frame) begin
                frame_q  <= make_frame((byte_cnt == 2'd0) ? PS2_BREAK : code_q);
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt + 1'b1;
            end
            done <= set_done;
            err  <= set_err;
        end
    end

endmodule
